demux3_buf: RTL and testbench
=============================

# demux3_buf

Registered 1-to-3 demultiplexer for the pipeline datapath, the write-side counterpart of the 3-way select mux: one producer stream, steered by a 2-bit select, is delivered into one of three single-entry output buffers, each with its own valid/ready handshake. Sits between a producer stage (e.g. issue/forward source) and three consumer slots, decoupling backpressure per destination. Select value 2'b11 is the "no destination" code: data is consumed and discarded, and counted.

## Interface
- WIDTH, 64, data width of input and every output channel
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all three output buffers
- in_valid  input  1  producer has a word this cycle
- in_data  input  WIDTH  producer word
- in_sel  input  u2  destination: 00→ch0, 01→ch1, 10→ch2, 11→discard
- in_ready  output  1  word accepted this cycle when in_valid && in_ready
- out_valid  output  3  per-channel buffer full (bit i = channel i)
- out_data0, out_data1, out_data2  output  WIDTH  channel buffer contents
- out_ready  input  3  per-channel consumer accepts this cycle
- drop_cnt  output  8  saturating count of discarded (sel=11) words

## Operation
- Each channel i holds one register pair {vld[i], data[i]}; out_valid[i]=vld[i], out_data_i=data[i].
- Channel i drains when vld[i] && out_ready[i]; vld[i] clears next cycle unless refilled the same cycle.
- in_ready (combinational): 0 if flush; else 1 if in_sel==11; else !vld[in_sel] || out_ready[in_sel]. Combinational path from out_ready/in_sel to in_ready is intended.
- Accept (in_valid && in_ready), sel=i∈{0,1,2}: data[i]<=in_data, vld[i]<=1. Other channels unaffected.
- Accept, sel=11: nothing stored; drop_cnt<=drop_cnt+1, saturating at 8'hFF.
- Simultaneous drain and fill of same channel: new word loaded, vld stays 1 (no bubble).
- out_data_i holds last value when vld[i]=0 (not cleared on drain).
- flush=1: all vld<=0 next edge, data registers unchanged, in_ready=0 so no accept that cycle; drop_cnt not cleared. flush takes priority over drain/fill.
- in_valid=0: in_sel ignored, no state change except drains.

## Timing
- Reset (resetn=0, asynchronous): out_valid=3'b000, all out_data=0, drop_cnt=0. in_ready reflects combinational rule (1 when flush=0 and target empty).
- Reset deassertion mid-stream: state restarts empty; any in-flight word is lost.
- Latency: word accepted at edge N is visible on out_valid/out_data from cycle N+1.
- Throughput: one word per cycle per channel when consumer holds out_ready=1.
- Outputs are stable while out_valid[i]=1 and out_ready[i]=0 (consumer may sample any cycle).
- Producer must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
- drop_cnt updates at the edge of the accepting cycle; stays 8'hFF once saturated.

## Test plan
- Reset: assert resetn=0 asynchronously mid-cycle with ch1 full → out_valid=000, out_data*=0, drop_cnt=0 immediately; after release, in_valid=1,sel=01,data=0xAB → out_valid=010, out_data1=0xAB next cycle.
- Backpressure: fill ch0 with 0x11, hold out_ready=000, present sel=00 data 0x22 → in_ready=0 for 5 cycles, out_data0 stays 0x11; raise out_ready[0] → same cycle in_ready=1, next cycle out_data0=0x22, out_valid[0]=1.
- Independence: ch2 full and stalled, send sel=00 0x33 and sel=01 0x44 back-to-back → both accepted, out_valid=111, ch2 unchanged.
- Streaming: out_ready=001, 8 consecutive sel=00 words 1..8 → in_ready=1 every cycle, out_data0 sequence 1..8 with no bubble.
- Discard: 260 words with sel=11 → in_ready=1 each, no out_valid change, drop_cnt=255 after the 255th and stays 255.
- Flush: out_valid=111, flush=1 with in_valid=1 sel=00 → in_ready=0, next cycle out_valid=000, drop_cnt unchanged; following cycle with flush=0 word accepted.

Source files
------------

// File: rtl/demux3_buf.sv
// Registered 1-to-3 demultiplexer: one producer stream steered into three
// single-entry output buffers; select 2'b11 discards the word and counts it.
module demux3_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic [2:0]       out_valid,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  input  logic [2:0]       out_ready,
  output logic [7:0]       drop_cnt
);

  localparam logic [1:0] SEL_DROP = 2'b11;

  logic [2:0]       vld;
  logic [WIDTH-1:0] data [3];
  logic             accept;

  // A channel can take a word if it is empty or draining this same cycle.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      unique case (in_sel)
        2'b00:   in_ready = !vld[0] || out_ready[0];
        2'b01:   in_ready = !vld[1] || out_ready[1];
        2'b10:   in_ready = !vld[2] || out_ready[2];
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // Flush wins over drain and fill; a fill on a draining channel keeps vld high.
  // NOTE: state uses non-blocking assignments; the data registers are reset
  // too, because the buffers must read as zero straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld <= 3'b000;
      for (int i = 0; i < 3; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flush) begin
          vld[i] <= 1'b0;
        end else if (accept && in_sel == 2'(i)) begin
          vld[i]  <= 1'b1;
          data[i] <= in_data;
        end else if (out_ready[i]) begin
          vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= 8'h00;
    end else if (accept && in_sel == SEL_DROP && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign out_valid = vld;
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];

endmodule

// File: tb/tb_demux3_buf.sv
// Directed self-checking bench for demux3_buf: reset, backpressure,
// channel independence, streaming, discard saturation and flush.
module tb_demux3_buf;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_ready;
  logic [2:0]       out_valid;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [2:0]       out_ready;
  logic [7:0]       drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  demux3_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'b00;
    out_ready = 3'b000;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    resetn = 1'b1;
    step();

    // Fill ch1, then pull reset asynchronously mid-cycle.
    in_valid = 1'b1; in_sel = 2'b01; in_data = 64'h55;
    step();
    in_valid = 1'b0;
    check("fill_ch1_valid", 64'(out_valid), 64'h2);
    check("fill_ch1_data", out_data1, 64'h55);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_data1", out_data1, 64'h0);
    check("async_rst_drop", 64'(drop_cnt), 64'h0);
    #1 resetn = 1'b1;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 64'hAB;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'h2);
    check("post_rst_data1", out_data1, 64'hAB);

    // Backpressure on ch0.
    in_valid = 1'b1; in_sel = 2'b00; in_data = 64'h11;
    step();
    in_data = 64'h22;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_in_ready_low", 64'(in_ready), 64'h0);
      step();
      check("bp_data0_hold", out_data0, 64'h11);
    end
    out_ready = 3'b001;
    #1 check("bp_in_ready_release", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0; out_ready = 3'b000;
    check("bp_data0_new", out_data0, 64'h22);
    check("bp_valid", 64'(out_valid), 64'h3);

    // Independence: drain ch0/ch1, stall ch2 full, fill ch0 and ch1 back-to-back.
    out_ready = 3'b011;
    step();
    out_ready = 3'b000;
    check("drain01_valid", 64'(out_valid), 64'h0);
    in_valid = 1'b1; in_sel = 2'b10; in_data = 64'h99;
    step();
    in_sel = 2'b00; in_data = 64'h33;
    #1 check("ind_ready_ch0", 64'(in_ready), 64'h1);
    step();
    in_sel = 2'b01; in_data = 64'h44;
    #1 check("ind_ready_ch1", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("ind_valid", 64'(out_valid), 64'h7);
    check("ind_data0", out_data0, 64'h33);
    check("ind_data1", out_data1, 64'h44);
    check("ind_data2", out_data2, 64'h99);

    // Streaming through ch0 with its consumer always ready.
    out_ready = 3'b001; in_valid = 1'b1; in_sel = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      in_data = 64'(k);
      #1 check("stream_in_ready", 64'(in_ready), 64'h1);
      step();
      check("stream_data0", out_data0, 64'(k));
      check("stream_valid0", 64'(out_valid[0]), 64'h1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 3'b000;
    check("stream_drained", 64'(out_valid), 64'h6);
    check("stream_hold_data0", out_data0, 64'h8);

    // Discard: drop_cnt saturates at 255.
    in_valid = 1'b1; in_sel = 2'b11;
    for (int k = 1; k <= 260; k++) begin
      in_data = 64'(k);
      #1 check("drop_in_ready", 64'(in_ready), 64'h1);
      step();
      check("drop_cnt", 64'(drop_cnt), (k < 255) ? 64'(k) : 64'd255);
    end
    in_valid = 1'b0;
    check("drop_valid_unchanged", 64'(out_valid), 64'h6);

    // Flush with all channels full.
    in_valid = 1'b1; in_sel = 2'b00; in_data = 64'h77;
    step();
    check("flush_pre_valid", 64'(out_valid), 64'h7);
    flush = 1'b1; in_data = 64'h88;
    #1 check("flush_in_ready", 64'(in_ready), 64'h0);
    step();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_data0_kept", out_data0, 64'h77);
    check("flush_drop_kept", 64'(drop_cnt), 64'd255);
    #1 check("post_flush_in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("post_flush_valid", 64'(out_valid), 64'h1);
    check("post_flush_data0", out_data0, 64'h88);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
